// File: rtl/parity_stream_checker_if.sv
// ---------------------------------------------------------------------------
// parity_stream_checker_if
//   Bundles the beat stream, the configuration/clear inputs and the result
//   outputs of parity_stream_checker. The clock and reset stay plain ports
//   on the checker itself.
//
//   Parameters
//     DATA_W      data word width in bits (1..64)
//     CNT_W       error counter width in bits (1..32)
//
//   Signals (direction as seen by the checker, i.e. the slave modport)
//     in_valid    in   current beat is valid
//     in_data     in   data word
//     in_parity   in   parity bit sent with in_data
//     in_last     in   current beat closes its frame
//     mode        in   0 = odd parity, 1 = even parity
//     clr         in   clears sticky_err and err_cnt
//     out_valid   out  a beat result is present this cycle
//     beat_err    out  reported beat failed its parity check
//     frame_done  out  reported beat closed a frame
//     frame_err   out  at least one beat of the closed frame failed
//     sticky_err  out  a beat failed since the last rst or clr
//     err_cnt     out  saturating count of failed beats
//     busy        out  checker is inside a frame
// ---------------------------------------------------------------------------
interface parity_stream_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              in_last;
  logic              mode;
  logic              clr;

  logic              out_valid;
  logic              beat_err;
  logic              frame_done;
  logic              frame_err;
  logic              sticky_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              busy;

  // Stream source / result sink (testbench or upstream logic).
  modport master (
    output in_valid,
    output in_data,
    output in_parity,
    output in_last,
    output mode,
    output clr,
    input  out_valid,
    input  beat_err,
    input  frame_done,
    input  frame_err,
    input  sticky_err,
    input  err_cnt,
    input  busy
  );

  // The checker itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_parity,
    input  in_last,
    input  mode,
    input  clr,
    output out_valid,
    output beat_err,
    output frame_done,
    output frame_err,
    output sticky_err,
    output err_cnt,
    output busy
  );

endinterface

// File: rtl/parity_stream_checker.sv
// ---------------------------------------------------------------------------
// parity_stream_checker
//   Checks the parity of every beat of a framed data stream, reports a
//   registered per-beat result one cycle after acceptance, flags frames
//   that contained at least one bad beat, and keeps a sticky error flag
//   plus a saturating error counter that software can clear.
//
//   Ports
//     clk    in   single clock, all registers update on its rising edge
//     rst    in   synchronous active-high reset, wins over everything
//     bus    slave modport of parity_stream_checker_if (stream in,
//                 results out; see the interface file for the list)
//
//   FSM
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     IDLE     | between frames; next valid beat starts a frame and
//              | latches the parity mode
//     IN_FRAME | first beat seen without in_last; waiting for the last beat
// ---------------------------------------------------------------------------
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  parity_stream_checker_if.slave bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic             r_mode;
  logic             r_acc;
  logic             r_out_valid;
  logic             r_beat_err;
  logic             r_frame_done;
  logic             r_frame_err;
  logic             r_sticky_err;
  logic [CNT_W-1:0] r_err_cnt;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_data;
  state_t            w_state_nxt;
  logic              w_first_beat;
  logic              w_mode_eff;
  logic              w_acc_eff;
  logic              w_parity;
  logic              w_fail;
  logic              w_beat_fail;
  logic              w_frame_fail;

  assign w_data = bus.in_data;

  // Next-state and beat evaluation.
  always_comb begin
    w_state_nxt  = r_state;
    w_first_beat = 1'b0;
    w_mode_eff   = r_mode;
    w_acc_eff    = r_acc;
    w_parity     = 1'b0;
    w_fail       = 1'b0;
    w_beat_fail  = 1'b0;
    w_frame_fail = 1'b0;

    // A beat taken in IDLE opens a frame: it uses the live mode and starts
    // from a clean accumulator, so stale state from an earlier frame can
    // never leak into this one.
    w_first_beat = (r_state == IDLE);
    if (w_first_beat) begin
      w_mode_eff = bus.mode;
      w_acc_eff  = 1'b0;
    end

    w_parity = (^w_data) ^ bus.in_parity;
    // Odd mode passes on P=1, even mode passes on P=0.
    w_fail       = w_mode_eff ? w_parity : ~w_parity;
    w_beat_fail  = bus.in_valid & w_fail;
    w_frame_fail = w_acc_eff | w_fail;

    case (r_state)
      IDLE: begin
        if (bus.in_valid && !bus.in_last) begin
          w_state_nxt = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (bus.in_valid && bus.in_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame context: latched mode and failure accumulator. clr has no
  // effect here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_acc  <= 1'b0;
    end else if (bus.in_valid) begin
      if (w_first_beat) begin
        r_mode <= bus.mode;
      end
      if (bus.in_last) begin
        r_acc <= 1'b0;
      end else begin
        r_acc <= w_frame_fail;
      end
    end
  end

  // Per-beat result registers; they pulse for exactly one cycle per beat
  // and read back as zero on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_beat_err   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_out_valid  <= bus.in_valid;
      r_beat_err   <= w_beat_fail;
      r_frame_done <= bus.in_valid & bus.in_last;
      r_frame_err  <= bus.in_valid & bus.in_last & w_frame_fail;
    end
  end

  // Sticky flag and saturating counter. A failing beat in the same cycle as
  // clr wins: the clear is applied first and the beat then counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_err <= 1'b0;
      r_err_cnt    <= CNT_ZERO;
    end else if (w_beat_fail) begin
      r_sticky_err <= 1'b1;
      if (bus.clr) begin
        r_err_cnt <= CNT_ONE;
      end else if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end
    end else if (bus.clr) begin
      r_sticky_err <= 1'b0;
      r_err_cnt    <= CNT_ZERO;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.out_valid  = r_out_valid;
  assign bus.beat_err   = r_beat_err;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.sticky_err = r_sticky_err;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.busy       = (r_state == IN_FRAME);

endmodule

// File: tb/tb_parity_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_stream_checker
//   Two checkers share one stimulus stream: the default build (CNT_W=8) and
//   a CNT_W=2 build that exercises counter saturation. A reference model is
//   advanced as each cycle's inputs are driven; per-beat expectations go into
//   a queue and are popped when out_valid is seen on the following cycle.
// ---------------------------------------------------------------------------
module tb_parity_stream_checker;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int SAT_W  = 2;

  logic clk;
  logic rst;

  parity_stream_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  parity_stream_checker_if #(.DATA_W(DATA_W), .CNT_W(SAT_W)) bus_sat ();

  parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(SAT_W)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.in_data   = bus.in_data;
  assign bus_sat.in_parity = bus.in_parity;
  assign bus_sat.in_last   = bus.in_last;
  assign bus_sat.mode      = bus.mode;
  assign bus_sat.clr       = bus.clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic beat_err;
    logic frame_done;
    logic frame_err;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_bad = 0;

  // reference model state (values after the most recently driven edge)
  logic       m_busy;
  logic       m_mode;
  logic       m_acc;
  logic       m_sticky;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt_sat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_mode    = 1'b0;
    m_acc     = 1'b0;
    m_sticky  = 1'b0;
    m_cnt     = '0;
    m_cnt_sat = '0;
    exp_q.delete();
  endtask

  // One clock cycle: check what the previous edge produced, then drive the
  // inputs for the next edge and advance the model.
  task automatic cycle(input logic v, input logic [7:0] data, input logic par,
                       input logic last, input logic md, input logic c,
                       input logic r);
    exp_t e;
    logic mode_eff, p, fail, acc_eff;
    @(negedge clk);
    chk("busy", bus.busy, m_busy);
    chk("sat_busy", bus_sat.busy, m_busy);
    chk("sticky", bus.sticky_err, m_sticky);
    chk("err_cnt", bus.err_cnt, m_cnt);
    chk("sat_cnt", bus_sat.err_cnt, m_cnt_sat);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_err", bus.beat_err, e.beat_err);
        chk("frame_done", bus.frame_done, e.frame_done);
        chk("frame_err", bus.frame_err, e.frame_err);
        chk("sat_beat_err", bus_sat.beat_err, e.beat_err);
      end
    end else begin
      chk("missing_out", exp_q.size(), 0);
      chk("idle_outs", {bus.beat_err, bus.frame_done, bus.frame_err}, 3'b000);
      exp_q.delete();
    end

    bus.in_valid  = v;
    bus.in_data   = data;
    bus.in_parity = par;
    bus.in_last   = last;
    bus.mode      = md;
    bus.clr       = c;
    rst           = r;

    if (r) begin
      model_reset();
    end else begin
      fail = 1'b0;
      if (v) begin
        mode_eff = m_busy ? m_mode : md;
        acc_eff  = m_busy ? m_acc : 1'b0;
        p        = (^data) ^ par;
        fail     = mode_eff ? p : ~p;
        e.beat_err   = fail;
        e.frame_done = last;
        e.frame_err  = last & (acc_eff | fail);
        exp_q.push_back(e);
        if (!m_busy) m_mode = md;
        m_acc  = last ? 1'b0 : (acc_eff | fail);
        m_busy = ~last;
      end
      if (fail) begin
        m_sticky  = 1'b1;
        m_cnt     = c ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
        m_cnt_sat = c ? 2'd1 : ((m_cnt_sat == 2'd3) ? m_cnt_sat : m_cnt_sat + 2'd1);
      end else if (c) begin
        m_sticky  = 1'b0;
        m_cnt     = '0;
        m_cnt_sat = '0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_parity = 1'b0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.clr       = 1'b0;
    rst           = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state
    idle();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_cnt", bus.err_cnt, 0);

    // single-beat frame, even mode, good parity
    cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("single_done", bus.frame_done, 1'b1);
    chk("single_ferr", bus.frame_err, 1'b0);

    // odd-mode failure
    cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("odd_fail_cnt", bus.err_cnt, 1);
    chk("odd_fail_sticky", bus.sticky_err, 1'b1);

    // three-beat even frame, bad middle beat, mode toggled mid-frame
    cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("multi_ferr", bus.frame_err, 1'b1);
    chk("multi_beat3_err", bus.beat_err, 1'b0);

    // clr alone, then five failed beats: saturating build goes 1,2,3,3,3
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle();
    chk("sat_final", bus_sat.err_cnt, 3);
    chk("cnt_after5", bus.err_cnt, 5);

    // clr colliding with a failed beat, then clr alone
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("clr_collide_cnt", bus.err_cnt, 1);
    chk("clr_collide_sticky", bus.sticky_err, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("clr_alone_cnt", bus.err_cnt, 0);
    chk("clr_alone_sticky", bus.sticky_err, 1'b0);

    // reset mid-frame with a beat on the reset edge, then a good single beat
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.frame_done, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("post_rst_done", bus.frame_done, 1'b1);
    chk("post_rst_ferr", bus.frame_err, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), 1'b0);
    end
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
